interval_meter: RTL

INTERVAL_METER -- requirements
Module: interval_meter

---
 rtl/interval_meter_pkg.sv | 13 +
 rtl/interval_meter_if.sv | 27 ++
 rtl/interval_meter_result.sv | 64 ++++++
 rtl/interval_meter.sv | 89 ++++++++
 4 files changed

// File: rtl/interval_meter_pkg.sv
// Shared types and constants for the interval meter.
// Holds the FSM state encoding and the default count width.
package interval_meter_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/interval_meter_if.sv
// Result bus of the interval meter: measurement plus valid/ready handshake and status flags.
// master = producer (meter), slave = consumer.
interface interval_meter_if #(
    parameter int WIDTH = interval_meter_pkg::WIDTH_DEFAULT
);
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overflow;
    logic             missed;

    modport master (
        output result,
        output result_valid,
        output overflow,
        output missed,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        input  overflow,
        input  missed,
        output result_ready
    );
endinterface

// File: rtl/interval_meter_result.sv
// Purpose: single-entry holding register for completed measurements, with sticky drop flag.
// Latency: result/result_valid update on the edge after done_vld.
// Backpressure: a completion while an unread result is held is dropped and flags missed.
module interval_meter_result #(
    parameter int WIDTH = interval_meter_pkg::WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             done_vld,
    input  logic [WIDTH-1:0] done_cnt,
    input  logic             done_ovf,
    interval_meter_if.master res_if
);

    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             missed_q, missed_d;
    logic             hs, accept, drop;

    assign hs     = valid_q & res_if.result_ready;
    assign accept = done_vld & (~valid_q | res_if.result_ready);
    assign drop   = done_vld & valid_q & ~res_if.result_ready;

    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;
        if (accept) begin
            result_d = done_cnt;
            ovf_d    = done_ovf;
            valid_d  = 1'b1;
        end else if (hs) begin
            valid_d  = 1'b0;
        end
        // A drop cannot coincide with a handshake, so set-wins ordering is moot.
        if (drop) begin
            missed_d = 1'b1;
        end else if (hs) begin
            missed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
        end
    end

    assign res_if.result       = result_q;
    assign res_if.result_valid = valid_q;
    assign res_if.overflow     = ovf_q;
    assign res_if.missed       = missed_q;

endmodule

// File: rtl/interval_meter.sv
// Purpose: measures the high time of sig_in in clk cycles after an arm pulse (INTERVAL_METER_SAT_EN: saturating count).
// Latency: result_valid rises one cycle after the first low sample ending the pulse.
// Backpressure: result_ready=0 holds the result; later completions are dropped and flag missed.
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             continuous,
    input  logic             sig_in,
    output logic             measuring,
    interval_meter_if.master res_if
);

    state_t           state_q, state_d;
    logic             sig_d_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             rise;
    logic             done;

    assign rise = sig_in & ~sig_d_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
            end
            ARMED: begin
                // Only an edge starts a measurement; a level already high is skipped.
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = WIDTH'(1);
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (sig_in) begin
`ifdef INTERVAL_METER_SAT_EN
                    if (cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
`else
                    cnt_d = cnt_q + WIDTH'(1);
`endif
                end else begin
                    done    = 1'b1;
                    state_d = continuous ? ARMED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sig_d_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_d_q <= sig_in;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign measuring = (state_q == MEASURE);

    interval_meter_result #(.WIDTH(WIDTH)) u_result (
        .clk      (clk),
        .reset_n  (reset_n),
        .done_vld (done),
        .done_cnt (cnt_q),
        .done_ovf (sat_q),
        .res_if   (res_if)
    );

endmodule
